// File: rtl/inst_rom_bootld_pkg.sv
// rtl/inst_rom_bootld_pkg.sv - shared types and constants for the boot-loading instruction ROM
package inst_rom_bootld_pkg;

    typedef enum logic [2:0] {
        BLD_HDR  = 3'd0,
        BLD_LOAD = 3'd1,
        BLD_CSUM = 3'd2,
        BLD_DONE = 3'd3,
        BLD_ERR  = 3'd4
    } bld_state_e;

    localparam int          LD_BYTE_W = 8;
    localparam int          INST_W    = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/bootld_packer.sv
// rtl/bootld_packer.sv - packs big-endian bytes into 32-bit words, one-cycle word strobe on the 4th byte
module bootld_packer
    import inst_rom_bootld_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid_i,
    input  logic [LD_BYTE_W-1:0] byte_i,
    input  logic                 clear_i,
    output logic                 word_valid_o,
    output logic [INST_W-1:0]    word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // The completed word is formed combinationally so it can be written on the same edge.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'h0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'h0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/inst_rom_bootld.sv
// rtl/inst_rom_bootld.sv - instruction memory with byte-stream boot loader; optional checksum via BOOTLD_CSUM_EN
module inst_rom_bootld
    import inst_rom_bootld_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int CORE_RST_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LD_BYTE_W-1:0] ld_byte_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic                 rom_ce_i,
    input  logic [31:0]          rom_addr_i,
    output logic [INST_W-1:0]    rom_data_o,
    output logic                 core_rst_o,
    output logic                 ld_done_o,
    output logic                 ld_err_o
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [31:0]       DEPTH_W  = 32'd1 << ADDR_WIDTH;
    localparam int                HOLD_W   = (CORE_RST_HOLD > 0) ? $clog2(CORE_RST_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CORE_RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);
`ifdef BOOTLD_CSUM_EN
    localparam bld_state_e LOAD_END = BLD_CSUM;
`else
    localparam bld_state_e LOAD_END = BLD_DONE;
`endif

    bld_state_e          state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] n_q, n_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
`ifdef BOOTLD_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic              accept;
    logic              pk_clear;
    logic              pk_word_valid;
    logic [INST_W-1:0] pk_word;
    logic              mem_we;
    logic [INST_W-1:0] mem [0:DEPTH-1];

    assign ld_ready_o = (state_q == BLD_HDR) || (state_q == BLD_LOAD) || (state_q == BLD_CSUM);
    assign accept     = ld_valid_i && ld_ready_o;
    assign ld_done_o  = (state_q == BLD_DONE);
    assign ld_err_o   = (state_q == BLD_ERR);
    assign core_rst_o = !((state_q == BLD_DONE) && (hold_q == HOLD_MAX));

    // Header and payload share one packer; it is realigned when the header completes.
    bootld_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (accept),
        .byte_i       (ld_byte_i),
        .clear_i      (pk_clear),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        n_d      = n_q;
        hold_d   = hold_q;
        pk_clear = 1'b0;
        mem_we   = 1'b0;
`ifdef BOOTLD_CSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            BLD_HDR: begin
                if (pk_word_valid) begin
                    if (pk_word == ZERO_WORD) begin
                        state_d = LOAD_END;
                    end else if (pk_word > DEPTH_W) begin
                        state_d = BLD_ERR;
                    end else begin
                        state_d  = BLD_LOAD;
                        n_d      = pk_word[ADDR_WIDTH:0];
                        wr_ptr_d = '0;
                        pk_clear = 1'b1;
                    end
                end
            end
            BLD_LOAD: begin
`ifdef BOOTLD_CSUM_EN
                if (accept) csum_d = csum_q ^ ld_byte_i;
`endif
                if (pk_word_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_d == n_q) state_d = LOAD_END;
                end
            end
`ifdef BOOTLD_CSUM_EN
            BLD_CSUM: begin
                if (accept) state_d = (ld_byte_i == csum_q) ? BLD_DONE : BLD_ERR;
            end
`endif
            BLD_DONE: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BLD_HDR;
            wr_ptr_q <= '0;
            n_q      <= '0;
            hold_q   <= '0;
`ifdef BOOTLD_CSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            n_q      <= n_d;
            hold_q   <= hold_d;
`ifdef BOOTLD_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Array contents deliberately survive rst so a partial reload keeps earlier words.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= pk_word;
    end

    logic [ADDR_WIDTH-1:0] rom_idx;
    logic                  rom_hi_set;
    logic [1:0]            unused_addr_lsb;

    assign rom_idx         = rom_addr_i[ADDR_WIDTH+1:2];
    assign rom_hi_set      = |(rom_addr_i >> (ADDR_WIDTH + 2));
    assign unused_addr_lsb = rom_addr_i[1:0];
    assign rom_data_o      = (rom_ce_i && !rom_hi_set) ? mem[rom_idx] : ZERO_WORD;

endmodule

// File: tb/tb_inst_rom_bootld.sv
// tb/tb_inst_rom_bootld.sv - directed and randomized self-checking bench for inst_rom_bootld
module tb_inst_rom_bootld;

    localparam int AW    = 10;
    localparam int HOLD  = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ld_byte_i = 8'h00;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic        rom_ce_i = 1'b0;
    logic [31:0] rom_addr_i = 32'h0;
    logic [31:0] rom_data_o;
    logic        core_rst_o;
    logic        ld_done_o;
    logic        ld_err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [0:DEPTH-1];
    logic        exp_done;
    logic        exp_err;

    always #5 clk = ~clk;

    inst_rom_bootld #(.ADDR_WIDTH(AW), .CORE_RST_HOLD(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_byte_i  (ld_byte_i),
        .ld_valid_i (ld_valid_i),
        .ld_ready_o (ld_ready_o),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .core_rst_o (core_rst_o),
        .ld_done_o  (ld_done_o),
        .ld_err_o   (ld_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        ld_valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input int gap_pct);
        while ($urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
        ld_byte_i  = b;
        ld_valid_i = 1'b1;
        @(posedge clk);
        #1 ld_valid_i = 1'b0;
    endtask

    task automatic rom_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
        #1 check(tag, rom_data_o, exp);
    endtask

    // Reference: an image is a header word N followed by N big-endian words; the outcome
    // depends only on N versus the array depth, and word i lands at index i.
    task automatic send_image(input logic [31:0] n, input logic [31:0] w[$], input int gap);
        logic [7:0] stream[$];
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) stream.push_back(8'(n >> (24 - 8 * i)));
        if (n <= DEPTH) begin
            for (int k = 0; k < w.size(); k++) begin
                for (int i = 0; i < 4; i++) begin
                    stream.push_back(8'(w[k] >> (24 - 8 * i)));
                    x ^= 8'(w[k] >> (24 - 8 * i));
                end
                exp_mem[k] = w[k];
            end
`ifdef BOOTLD_CSUM_EN
            stream.push_back(x);
`endif
        end
        exp_err  = (n > DEPTH);
        exp_done = !exp_err;
        foreach (stream[i]) push(stream[i], gap);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] inv[$];

        #2;
        check("reset_ready", 32'(ld_ready_o), 32'd1);
        check("reset_core_rst", 32'(core_rst_o), 32'd1);
        check("reset_done", 32'(ld_done_o), 32'd0);
        check("reset_err", 32'(ld_err_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two-word image and core release timing
        w = '{32'h3C011234, 32'h34215678};
        send_image(32'd2, w, 0);
        check("img2_done", 32'(ld_done_o), 32'(exp_done));
        check("img2_ready", 32'(ld_ready_o), 32'd0);
        for (int c = 1; c <= HOLD + 1; c++) begin
            check($sformatf("img2_core_rst_c%0d", c), 32'(core_rst_o), (c <= HOLD) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        check("img2_core_rst_stays", 32'(core_rst_o), 32'd0);
        rom_check("img2_mem0", 32'h0, exp_mem[0]);
        rom_check("img2_addr4", 32'h4, 32'h34215678);
        rom_check("img2_addr7_lsb_ignored", 32'h7, 32'h34215678);

        // Empty image
        do_reset();
        w = {};
        send_image(32'd0, w, 0);
        check("empty_done", 32'(ld_done_o), 32'd1);
        check("empty_ready", 32'(ld_ready_o), 32'd0);
        rom_check("empty_no_write", 32'h0, 32'h3C011234);

        // Oversize header
        do_reset();
        send_image(32'h0000_0401, w, 0);
        check("big_err", 32'(ld_err_o), 32'(exp_err));
        check("big_core_rst", 32'(core_rst_o), 32'd1);
        check("big_ready", 32'(ld_ready_o), 32'd0);
        push(8'h55, 0);
        push(8'h66, 0);
        check("big_err_sticky", 32'(ld_err_o), 32'd1);
        check("big_not_done", 32'(ld_done_o), 32'd0);
        check("big_still_not_ready", 32'(ld_ready_o), 32'd0);

        // 16 random words: gap-free, then overwritten, then reloaded with ~50% gaps
        w = {};
        inv = {};
        for (int i = 0; i < 16; i++) begin
            w.push_back($urandom);
            inv.push_back(~w[i]);
        end
        do_reset();
        send_image(32'd16, w, 0);
        check("rnd_done", 32'(ld_done_o), 32'd1);
        for (int i = 0; i < 16; i++) rom_check($sformatf("rnd_nogap_%0d", i), 32'(i * 4), exp_mem[i]);
        do_reset();
        send_image(32'd16, inv, 0);
        do_reset();
        send_image(32'd16, w, 50);
        check("rnd_gap_done", 32'(ld_done_o), 32'd1);
        for (int i = 0; i < 16; i++) rom_check($sformatf("rnd_gap_%0d", i), 32'(i * 4), w[i]);

        // rst mid-load, then reload one word
        do_reset();
        push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'h02, 0);
        push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0); push(8'hDD, 0);
        push(8'hEE, 0); push(8'hFF, 0);
        exp_mem[0] = 32'hAABBCCDD;
        rom_check("midload_word0", 32'h0, exp_mem[0]);
        rom_check("midload_word1_untouched", 32'h4, exp_mem[1]);
        do_reset();
        check("midrst_ready", 32'(ld_ready_o), 32'd1);
        check("midrst_done", 32'(ld_done_o), 32'd0);
        check("midrst_core_rst", 32'(core_rst_o), 32'd1);
        w = '{32'hDEADBEEF};
        send_image(32'd1, w, 0);
        check("reload_done", 32'(ld_done_o), 32'd1);
        rom_check("reload_mem0", 32'h0, 32'hDEADBEEF);
        rom_check("reload_mem1_kept", 32'h4, exp_mem[1]);
        rom_check("high_addr_zero", 32'h0001_0000, 32'h0);
        rom_ce_i = 1'b0;
        #1 check("ce_low_zero", rom_data_o, 32'h0);

`ifdef BOOTLD_CSUM_EN
        do_reset();
        push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'h01, 0);
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        check("csum_wait_ready", 32'(ld_ready_o), 32'd1);
        push(8'h44, 0);
        check("csum_ok_done", 32'(ld_done_o), 32'd1);
        do_reset();
        push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'h01, 0);
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        push(8'h45, 0);
        check("csum_bad_err", 32'(ld_err_o), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
